// File: rtl/icd_pkg.sv
// Shared constants and types for the image display controller host side:
// command codes, frame geometry, datapath widths and the ACK timeout.
package icd_pkg;

   typedef enum logic [2:0] {
      CMD_WRITE       = 3'd0,
      CMD_SHIFT_UP    = 3'd1,
      CMD_SHIFT_DOWN  = 3'd2,
      CMD_SHIFT_LEFT  = 3'd3,
      CMD_SHIFT_RIGHT = 3'd4,
      CMD_AVERAGE     = 3'd5,
      CMD_MIRROR_X    = 3'd6,
      CMD_MIRROR_Y    = 3'd7
   } icd_cmd_e;

   localparam int IMG_PIXELS  = 64;
   localparam int CMD_W       = 3;
   localparam int PIX_W       = 8;
   localparam int ADDR_W      = 6;
   localparam int CNT_W       = 7;
   localparam int SUM_W       = 14;
   localparam int ACK_TIMEOUT = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_ACK   = 2'd2,
      ST_HOLD  = 2'd3
   } issue_state_e;

endpackage

// File: rtl/icd_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags. A push while full is
// dropped; full is judged on the occupancy at the start of the cycle, so a
// same-cycle pop never frees a slot for a concurrent push.
module icd_cmd_fifo #(
   parameter int FIFO_DEPTH = 4,
   parameter int WIDTH      = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == (PTR_W+1)'(FIFO_DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap since depth is a power of two
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents need no reset because occupancy gates every read
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/icd_cmd_host.sv
// Host-side counterpart of the image display controller: queues commands,
// issues them one at a time with a single-cycle cmd_valid while busy is low,
// and sums the 64-pixel IRB write-back frame.
// Optional build macro ICD_HOST_ADDR_CHECK_EN: when defined, every captured
// pixel address must equal the running pixel count or addr_err latches high.
module icd_cmd_host
   import icd_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  q_cmd,
   input  logic        q_valid,
   output logic        q_ready,
   output logic [2:0]  cmd,
   output logic        cmd_valid,
   input  logic        busy,
   input  logic        IRB_RW,
   input  logic [5:0]  IRB_A,
   input  logic [7:0]  IRB_D,
   input  logic        done,
   output logic [13:0] frame_sum,
   output logic        frame_valid,
   output logic        addr_err
);

   localparam int ACK_W = $clog2(ACK_TIMEOUT);
   localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

   issue_state_e     state;
   issue_state_e     next_state;
   logic [ACK_W-1:0] ack_cnt;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;
   logic [CMD_W-1:0] fifo_head;
   logic             issue_next;
   logic             arm_capture;
   logic             armed;
   logic             accept_p0;
   logic             done_p1;
   logic             done_rise;
   logic [CNT_W-1:0] pix_cnt;
   logic [SUM_W-1:0] acc;

   // Pixel accumulate; 64 x 255 fits in SUM_W, so no saturation is needed
   function automatic logic [SUM_W-1:0] pix_add(input logic [SUM_W-1:0] a,
                                                input logic [PIX_W-1:0] d);
      return a + SUM_W'(d);
   endfunction

   icd_cmd_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .WIDTH      (CMD_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (q_valid),
      .push_data (q_cmd),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign q_ready = !fifo_full;

   // Issue FSM state register plus the busy-low counter used only in ACK
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         ack_cnt <= '0;
      end else begin
         state   <= next_state;
         ack_cnt <= (state == ST_ACK) ? ack_cnt + 1'b1 : '0;
      end
   end

   // Next-state: busy is deliberately not looked at in ISSUE
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (!fifo_empty && !busy) next_state = ST_ISSUE;
         ST_ISSUE: next_state = ST_ACK;
         ST_ACK: begin
            if (busy)                     next_state = ST_HOLD;
            else if (ack_cnt == ACK_LAST) next_state = ST_IDLE;
         end
         ST_HOLD:  if (!busy) next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   // FSM outputs: pop and arm in ISSUE; strobe is precomputed so it can be registered
   always_comb begin
      fifo_pop    = (state == ST_ISSUE);
      arm_capture = (state == ST_ISSUE) && (fifo_head == CMD_WRITE);
      issue_next  = (next_state == ST_ISSUE);
   end

   // Registered command outputs; cmd holds the last issued code between strobes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_valid <= 1'b0;
         cmd       <= '0;
      end else begin
         cmd_valid <= issue_next;
         if (issue_next) cmd <= fifo_head;
      end
   end

   // ---- stage p0: raw IRB sample; p1: previous done for edge detect ----
   assign accept_p0 = !IRB_RW;
   assign done_rise = done && !done_p1;

   // Frame capture: accumulate every write; a done edge mid-frame abandons it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done_p1     <= 1'b0;
         armed       <= 1'b0;
         pix_cnt     <= '0;
         acc         <= '0;
         frame_sum   <= '0;
         frame_valid <= 1'b0;
      end else begin
         done_p1     <= done;
         frame_valid <= 1'b0;
         armed       <= armed | arm_capture;
         if (done_rise && (pix_cnt != '0)) begin
            pix_cnt <= '0;
            acc     <= '0;
         end else if (accept_p0) begin
            if (pix_cnt == CNT_W'(IMG_PIXELS - 1)) begin
               frame_sum   <= pix_add(acc, IRB_D);
               frame_valid <= 1'b1;
               pix_cnt     <= '0;
               acc         <= '0;
               armed       <= 1'b0;
            end else begin
               acc     <= pix_add(acc, IRB_D);
               pix_cnt <= pix_cnt + 1'b1;
            end
         end
      end
   end

`ifdef ICD_HOST_ADDR_CHECK_EN
   // Sticky flag for any write whose address departs from the running count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         addr_err <= 1'b0;
      else if (accept_p0 && (IRB_A != pix_cnt[ADDR_W-1:0]))
         addr_err <= 1'b1;
   end
`else
   logic unused_irb_a;
   assign unused_irb_a = ^IRB_A;
   assign addr_err     = 1'b0;
`endif

endmodule

// File: tb/tb_icd_cmd_host.sv
// Directed self-checking bench for icd_cmd_host: command issue timing,
// queue overflow and ordering, write-back checksums, the optional address
// check, done-abort and asynchronous reset in mid-frame.
module tb_icd_cmd_host;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  q_cmd;
   logic        q_valid;
   logic        q_ready;
   logic [2:0]  cmd;
   logic        cmd_valid;
   logic        busy;
   logic        IRB_RW;
   logic [5:0]  IRB_A;
   logic [7:0]  IRB_D;
   logic        done;
   logic [13:0] frame_sum;
   logic        frame_valid;
   logic        addr_err;

   int total = 0;
   int bad   = 0;

   icd_cmd_host #(.FIFO_DEPTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .q_cmd       (q_cmd),
      .q_valid     (q_valid),
      .q_ready     (q_ready),
      .cmd         (cmd),
      .cmd_valid   (cmd_valid),
      .busy        (busy),
      .IRB_RW      (IRB_RW),
      .IRB_A       (IRB_A),
      .IRB_D       (IRB_D),
      .done        (done),
      .frame_sum   (frame_sum),
      .frame_valid (frame_valid),
      .addr_err    (addr_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic write_pix(input int a, input int d);
      IRB_RW = 1'b0;
      IRB_A  = 6'(a);
      IRB_D  = 8'(d);
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #1;
      total++;
      if ({cmd_valid, cmd, q_ready, frame_sum, frame_valid, addr_err} !== {1'b0, 3'd0, 1'b1, 14'd0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset_values got cv=%0b cmd=%0d rdy=%0b sum=%0d fv=%0b ae=%0b want 0 0 1 0 0 0",
                  cmd_valid, cmd, q_ready, frame_sum, frame_valid, addr_err);
      end
      tick();
      tick();
      reset = 1'b1;
      tick();
      total++;
      if ({cmd_valid, q_ready, frame_valid} !== 3'b010) begin
         bad++;
         $display("FAIL reset_release got cv=%0b rdy=%0b fv=%0b want 0 1 0", cmd_valid, q_ready, frame_valid);
      end
   endtask

   task automatic test_single_command();
      int pulses;
      apply_reset();
      busy = 1'b0; q_cmd = 3'd5; q_valid = 1'b1;
      tick();
      q_valid = 1'b0;
      total++;
      if (cmd_valid !== 1'b0) begin
         bad++; $display("FAIL single_early got cv=%0b want 0", cmd_valid);
      end
      tick();
      total++;
      if ({cmd_valid, cmd} !== {1'b1, 3'd5}) begin
         bad++; $display("FAIL single_issue got cv=%0b cmd=%0d want 1 5", cmd_valid, cmd);
      end
      busy = 1'b1; q_cmd = 3'd3; q_valid = 1'b1;
      tick();
      q_valid = 1'b0;
      pulses = int'(cmd_valid);
      tick(); pulses += int'(cmd_valid);
      tick(); pulses += int'(cmd_valid);
      busy = 1'b0;
      tick(); pulses += int'(cmd_valid);
      total++;
      if (pulses !== 0) begin
         bad++; $display("FAIL single_no_reissue got pulses=%0d want 0", pulses);
      end
      tick();
      total++;
      if ({cmd_valid, cmd} !== {1'b1, 3'd3}) begin
         bad++; $display("FAIL single_next_issue got cv=%0b cmd=%0d want 1 3", cmd_valid, cmd);
      end
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         tick(); pulses += int'(cmd_valid);
      end
      total++;
      if (pulses !== 0) begin
         bad++; $display("FAIL single_drain got pulses=%0d want 0", pulses);
      end
   endtask

   task automatic test_queue_full();
      logic [2:0] qcmds [5];
      int n;
      qcmds = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
      apply_reset();
      busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         q_cmd = qcmds[i]; q_valid = 1'b1;
         total++;
         if (q_ready !== (i < 4)) begin
            bad++; $display("FAIL qfull_ready_%0d got %0b want %0b", i, q_ready, (i < 4));
         end
         tick();
      end
      q_valid = 1'b0;
      total++;
      if (q_ready !== 1'b0) begin
         bad++; $display("FAIL qfull_after got rdy=%0b want 0", q_ready);
      end
      busy = 1'b0;
      n = 0;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (cmd_valid === 1'b1) begin
            if (n < 4) begin
               total++;
               if (cmd !== qcmds[n]) begin
                  bad++; $display("FAIL qfull_order_%0d got cmd=%0d want %0d", n, cmd, qcmds[n]);
               end
            end
            n++;
         end
      end
      total++;
      if (n !== 4) begin
         bad++; $display("FAIL qfull_count got issues=%0d want 4", n);
      end
      total++;
      if (q_ready !== 1'b1) begin
         bad++; $display("FAIL qfull_drained got rdy=%0b want 1", q_ready);
      end
   endtask

   task automatic test_writeback();
      logic seen;
      logic [2:0] got;
      int fv_early;
      apply_reset();
      busy = 1'b0; q_cmd = 3'd0; q_valid = 1'b1;
      tick();
      q_valid = 1'b0;
      seen = 1'b0; got = 3'd7;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (cmd_valid === 1'b1 && !seen) begin
            seen = 1'b1; got = cmd;
         end
      end
      total++;
      if (!(seen === 1'b1 && got === 3'd0)) begin
         bad++; $display("FAIL wb_cmd got seen=%0b cmd=%0d want 1 0", seen, got);
      end
      fv_early = 0;
      for (int i = 0; i < 64; i++) begin
         write_pix(i, i);
         if (i < 63) fv_early += int'(frame_valid);
      end
      IRB_RW = 1'b1;
      total++;
      if ({frame_valid, frame_sum} !== {1'b1, 14'd2016}) begin
         bad++; $display("FAIL wb_sum got fv=%0b sum=%0d want 1 2016", frame_valid, frame_sum);
      end
      total++;
      if (fv_early !== 0) begin
         bad++; $display("FAIL wb_fv_early got %0d want 0", fv_early);
      end
      total++;
      if (addr_err !== 1'b0) begin
         bad++; $display("FAIL wb_addr_err got %0b want 0", addr_err);
      end
      tick();
      total++;
      if ({frame_valid, frame_sum} !== {1'b0, 14'd2016}) begin
         bad++; $display("FAIL wb_fv_single got fv=%0b sum=%0d want 0 2016", frame_valid, frame_sum);
      end
   endtask

   task automatic test_all_max();
      for (int i = 0; i < 64; i++) write_pix(i, 255);
      IRB_RW = 1'b1;
      total++;
      if ({frame_valid, frame_sum} !== {1'b1, 14'd16320}) begin
         bad++; $display("FAIL max_sum got fv=%0b sum=%0d want 1 16320", frame_valid, frame_sum);
      end
      tick();
   endtask

   task automatic test_done_abort();
      for (int i = 0; i < 10; i++) write_pix(i, 9);
      IRB_RW = 1'b1; done = 1'b1;
      tick();
      done = 1'b0;
      total++;
      if (frame_valid !== 1'b0) begin
         bad++; $display("FAIL abort_no_fv got fv=%0b want 0", frame_valid);
      end
      tick();
      for (int i = 0; i < 64; i++) write_pix(i, 2);
      IRB_RW = 1'b1;
      total++;
      if ({frame_valid, frame_sum, addr_err} !== {1'b1, 14'd128, 1'b0}) begin
         bad++; $display("FAIL abort_sum got fv=%0b sum=%0d ae=%0b want 1 128 0", frame_valid, frame_sum, addr_err);
      end
      tick();
   endtask

   task automatic test_addr_err();
      logic exp_ae;
`ifdef ICD_HOST_ADDR_CHECK_EN
      exp_ae = 1'b1;
`else
      exp_ae = 1'b0;
`endif
      for (int i = 0; i < 64; i++) begin
         write_pix((i == 4) ? 5 : i, 1);
         if (i == 3) begin
            total++;
            if (addr_err !== 1'b0) begin
               bad++; $display("FAIL ae_before got %0b want 0", addr_err);
            end
         end
         if (i == 4) begin
            total++;
            if (addr_err !== exp_ae) begin
               bad++; $display("FAIL ae_set got %0b want %0b", addr_err, exp_ae);
            end
         end
      end
      IRB_RW = 1'b1;
      total++;
      if ({frame_valid, frame_sum} !== {1'b1, 14'd64}) begin
         bad++; $display("FAIL ae_sum got fv=%0b sum=%0d want 1 64", frame_valid, frame_sum);
      end
      tick(); tick();
      total++;
      if (addr_err !== exp_ae) begin
         bad++; $display("FAIL ae_sticky got %0b want %0b", addr_err, exp_ae);
      end
   endtask

   task automatic test_reset_midframe();
      int pulses;
      busy = 1'b1; q_cmd = 3'd2; q_valid = 1'b1;
      tick();
      q_valid = 1'b0;
      for (int i = 0; i < 30; i++) write_pix(i, 7);
      IRB_RW = 1'b1;
      reset = 1'b0;
      #1;
      total++;
      if ({cmd_valid, cmd, q_ready, frame_sum, frame_valid, addr_err} !== {1'b0, 3'd0, 1'b1, 14'd0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL rst_mid_values got cv=%0b cmd=%0d rdy=%0b sum=%0d fv=%0b ae=%0b want 0 0 1 0 0 0",
                  cmd_valid, cmd, q_ready, frame_sum, frame_valid, addr_err);
      end
      tick();
      reset = 1'b1; busy = 1'b0;
      tick();
      pulses = 0;
      for (int i = 0; i < 64; i++) begin
         write_pix(i, 1);
         pulses += int'(cmd_valid);
      end
      IRB_RW = 1'b1;
      total++;
      if ({frame_valid, frame_sum} !== {1'b1, 14'd64}) begin
         bad++; $display("FAIL rst_mid_sum got fv=%0b sum=%0d want 1 64", frame_valid, frame_sum);
      end
      total++;
      if (pulses !== 0) begin
         bad++; $display("FAIL rst_mid_queue_lost got pulses=%0d want 0", pulses);
      end
      tick();
   endtask

   initial begin
      reset = 1'b1; q_cmd = 3'd0; q_valid = 1'b0; busy = 1'b0;
      IRB_RW = 1'b1; IRB_A = 6'd0; IRB_D = 8'd0; done = 1'b0;
      #2;
      test_reset();
      test_single_command();
      test_queue_full();
      test_writeback();
      test_all_max();
      test_done_abort();
      test_addr_err();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
